iob_axistream_in_packer: RTL and testbench

//  Single-clock AXI-Stream sink. Packs TDATA_W-bit beats into DATA_W-bit words with
//  per-lane strobes and a last flag, and buffers them in an internal FWFT FIFO.
//  A CPU-side valid/ready port drains the FIFO. Partial packets are closed without

---
 rtl/iob_axistream_in_packer_if.sv | 13 +
 rtl/iob_axistream_in_packer.sv | 156 +++++++++++++++
 tb/tb_iob_axistream_in_packer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_axistream_in_packer_if.sv
// AXI-Stream beat channel feeding the packer: data, valid, last and the sink's ready.
// The source drives the master side; the packer sits on the slave side.
interface iob_axistream_in_packer_if #(
  parameter int TDATA_W = 8
);
  logic [TDATA_W-1:0] tdata;
  logic               tvalid;
  logic               tlast;
  logic               tready;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/iob_axistream_in_packer.sv
// AXI-Stream sink that packs TDATA_W beats into DATA_W words (strobes + last flag)
// and queues them in a first-word-fall-through FIFO drained by a valid/ready port.
module iob_axistream_in_packer #(
  parameter int TDATA_W         = 8,
  parameter int DATA_W          = 32,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                              clk_i,
  input  logic                              cke_i,
  input  logic                              rst_i,
  input  logic                              enable_i,
  iob_axistream_in_packer_if.slave          axis,
  output logic [DATA_W-1:0]                 data_o,
  output logic [DATA_W/TDATA_W-1:0]         strb_o,
  output logic                              last_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [FIFO_DEPTH_LOG2:0]          level_o,
  output logic [FIFO_DEPTH_LOG2:0]          pkt_cnt_o,
  input  logic [FIFO_DEPTH_LOG2:0]          threshold_i,
  input  logic                              lvl_int_en_i,
  input  logic                              pkt_int_en_i,
  output logic                              interrupt_o
);

  localparam int N      = DATA_W / TDATA_W;
  localparam int LANE_W = (N > 1) ? $clog2(N) : 1;
  localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int LVL_W  = FIFO_DEPTH_LOG2 + 1;
  localparam int PTR_W  = FIFO_DEPTH_LOG2;

  typedef enum logic {
    S_FILL,
    S_PUSH
  } state_t;

  state_t             state_q, state_d;
  logic [LANE_W-1:0]  lane_cnt_q, lane_cnt_d;
  logic [DATA_W-1:0]  pack_data_q, pack_data_d;
  logic [N-1:0]       pack_strb_q, pack_strb_d;
  logic               pack_last_q, pack_last_d;

  logic [DATA_W-1:0]  fifo_data_q [DEPTH];
  logic [N-1:0]       fifo_strb_q [DEPTH];
  logic               fifo_last_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [LVL_W-1:0]   pkt_cnt_q, pkt_cnt_d;

  logic full;
  logic push;
  logic pop;
  logic tready;
  logic accept;

  // Everything is qualified by cke and reset so a held or resetting block neither
  // accepts a beat nor moves the FIFO.
  assign full    = (level_q == LVL_W'(DEPTH));
  assign valid_o = (level_q != '0);
  assign push    = cke_i & ~rst_i & (state_q == S_PUSH) & ~full;
  assign pop     = cke_i & ~rst_i & valid_o & ready_i;
  assign tready  = cke_i & ~rst_i & enable_i & ((state_q == S_FILL) | ~full);
  assign accept  = axis.tvalid & tready;

  assign axis.tready = tready;

  // A push clears the pack registers first so a beat taken in the same cycle
  // lands in lane 0 of a fresh word.
  always_comb begin
    state_d     = state_q;
    lane_cnt_d  = lane_cnt_q;
    pack_data_d = pack_data_q;
    pack_strb_d = pack_strb_q;
    pack_last_d = pack_last_q;
    if (push) begin
      state_d     = S_FILL;
      pack_data_d = '0;
      pack_strb_d = '0;
      pack_last_d = 1'b0;
    end
    if (accept) begin
      pack_data_d[lane_cnt_q*TDATA_W +: TDATA_W] = axis.tdata;
      pack_strb_d[lane_cnt_q]                     = 1'b1;
      if ((lane_cnt_q == LANE_W'(N - 1)) || axis.tlast) begin
        state_d     = S_PUSH;
        pack_last_d = axis.tlast;
        lane_cnt_d  = '0;
      end else begin
        lane_cnt_d = lane_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    pkt_cnt_d = pkt_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    case ({push & pack_last_q, pop & last_o})
      2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
      2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_FILL;
      lane_cnt_q  <= '0;
      pack_data_q <= '0;
      pack_strb_q <= '0;
      pack_last_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pkt_cnt_q   <= '0;
    end else if (cke_i) begin
      state_q     <= state_d;
      lane_cnt_q  <= lane_cnt_d;
      pack_data_q <= pack_data_d;
      pack_strb_q <= pack_strb_d;
      pack_last_q <= pack_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= pack_data_q;
      fifo_strb_q[wr_ptr_q] <= pack_strb_q;
      fifo_last_q[wr_ptr_q] <= pack_last_q;
    end
  end

  assign data_o    = valid_o ? fifo_data_q[rd_ptr_q] : '0;
  assign strb_o    = valid_o ? fifo_strb_q[rd_ptr_q] : '0;
  assign last_o    = valid_o ? fifo_last_q[rd_ptr_q] : 1'b0;
  assign level_o   = level_q;
  assign pkt_cnt_o = pkt_cnt_q;

  assign interrupt_o = (lvl_int_en_i & (level_q > threshold_i)) |
                       (pkt_int_en_i & (pkt_cnt_q != '0));

endmodule

// File: tb/tb_iob_axistream_in_packer.sv
// Directed bench for iob_axistream_in_packer (8-bit beats, 32-bit words, 16-deep FIFO).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_iob_axistream_in_packer;

  localparam int TDATA_W = 8;
  localparam int DATA_W  = 32;
  localparam int LOG2    = 4;

  logic              clk = 1'b0;
  logic              cke;
  logic              rst;
  logic              enable;
  logic              ready;
  logic [LOG2:0]     threshold;
  logic              lvlIntEn;
  logic              pktIntEn;
  logic [DATA_W-1:0] dataOut;
  logic [3:0]        strbOut;
  logic              lastOut;
  logic              validOut;
  logic [LOG2:0]     levelOut;
  logic [LOG2:0]     pktCntOut;
  logic              intOut;

  int passCnt  = 0;
  int totalCnt = 0;
  int cycCnt   = 0;

  iob_axistream_in_packer_if #(.TDATA_W(TDATA_W)) axis ();

  iob_axistream_in_packer #(
    .TDATA_W(TDATA_W),
    .DATA_W(DATA_W),
    .FIFO_DEPTH_LOG2(LOG2)
  ) dut (
    .clk_i(clk),
    .cke_i(cke),
    .rst_i(rst),
    .enable_i(enable),
    .axis(axis),
    .data_o(dataOut),
    .strb_o(strbOut),
    .last_o(lastOut),
    .valid_o(validOut),
    .ready_i(ready),
    .level_o(levelOut),
    .pkt_cnt_o(pktCntOut),
    .threshold_i(threshold),
    .lvl_int_en_i(lvlIntEn),
    .pkt_int_en_i(pktIntEn),
    .interrupt_o(intOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycCnt++;

  // Presents one beat and waits (bounded) until the packer accepts it; returns on a falling edge.
  task automatic applyStimulus(input logic [7:0] d, input logic l);
    int waitCnt;
    waitCnt     = 0;
    axis.tdata  = d;
    axis.tvalid = 1'b1;
    axis.tlast  = l;
    #1;
    while (!axis.tready && waitCnt < 100) begin
      @(negedge clk);
      #1;
      waitCnt++;
    end
    if (!axis.tready) begin
      totalCnt++;
      $display("[TB] FAIL beat_accept: tready=%0b for beat %h, required 1 within 100 cycles", axis.tready, d);
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    enable      = 1'b1;
    axis.tvalid = 1'b1;
    axis.tdata  = 8'h5A;
    repeat (2) @(negedge clk);
    totalCnt++; if (axis.tready !== 1'b0) $display("[TB] FAIL rst_tready: got %b expected 0", axis.tready); else passCnt++;
    rst         = 1'b0;
    axis.tvalid = 1'b0;
    enable      = 1'b0;
    @(negedge clk);
    totalCnt++; if (validOut !== 1'b0) $display("[TB] FAIL rst_valid: got %b expected 0", validOut); else passCnt++;
    totalCnt++; if (levelOut !== 5'd0) $display("[TB] FAIL rst_level: got %0d expected 0", levelOut); else passCnt++;
    totalCnt++; if (pktCntOut !== 5'd0) $display("[TB] FAIL rst_pkt: got %0d expected 0", pktCntOut); else passCnt++;
    totalCnt++; if (intOut !== 1'b0) $display("[TB] FAIL rst_int: got %b expected 0", intOut); else passCnt++;
    totalCnt++; if ({dataOut, strbOut, lastOut} !== 37'd0) $display("[TB] FAIL rst_head: got %h/%b/%b expected 0/0/0", dataOut, strbOut, lastOut); else passCnt++;
    totalCnt++; if (axis.tready !== 1'b0) $display("[TB] FAIL disabled_tready: got %b expected 0", axis.tready); else passCnt++;
    enable = 1'b1;
    #1;
    totalCnt++; if (axis.tready !== 1'b1) $display("[TB] FAIL enabled_tready: got %b expected 1", axis.tready); else passCnt++;
    @(negedge clk);
  endtask

  task automatic test_full_word();
    ready = 1'b0;
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b0);
    applyStimulus(8'h33, 1'b0);
    applyStimulus(8'h44, 1'b1);
    totalCnt++; if (validOut !== 1'b0) $display("[TB] FAIL full_prepush_valid: got %b expected 0", validOut); else passCnt++;
    totalCnt++; if (axis.tready !== 1'b1) $display("[TB] FAIL full_push_tready: got %b expected 1", axis.tready); else passCnt++;
    @(negedge clk);
    totalCnt++; if (validOut !== 1'b1) $display("[TB] FAIL full_valid: got %b expected 1", validOut); else passCnt++;
    totalCnt++; if (dataOut !== 32'h44332211) $display("[TB] FAIL full_data: got %h expected 44332211", dataOut); else passCnt++;
    totalCnt++; if ({strbOut, lastOut} !== 5'b11111) $display("[TB] FAIL full_strb_last: got %b/%b expected 1111/1", strbOut, lastOut); else passCnt++;
    totalCnt++; if (pktCntOut !== 5'd1) $display("[TB] FAIL full_pkt: got %0d expected 1", pktCntOut); else passCnt++;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    totalCnt++; if ({validOut, levelOut, pktCntOut} !== 11'd0) $display("[TB] FAIL full_drain: got valid=%b level=%0d pkt=%0d expected 0/0/0", validOut, levelOut, pktCntOut); else passCnt++;
  endtask

  task automatic test_partial();
    int t0;
    ready = 1'b0;
    t0    = cycCnt;
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'hBB, 1'b1);
    totalCnt++; if (axis.tready !== 1'b1) $display("[TB] FAIL partial_push_tready: got %b expected 1", axis.tready); else passCnt++;
    applyStimulus(8'hCC, 1'b0);
    applyStimulus(8'hDD, 1'b0);
    applyStimulus(8'hEE, 1'b0);
    applyStimulus(8'hFF, 1'b1);
    totalCnt++; if (cycCnt - t0 !== 6) $display("[TB] FAIL partial_no_stall: took %0d cycles expected 6", cycCnt - t0); else passCnt++;
    @(negedge clk);
    totalCnt++; if (levelOut !== 5'd2) $display("[TB] FAIL partial_level: got %0d expected 2", levelOut); else passCnt++;
    totalCnt++; if (dataOut !== 32'h0000BBAA) $display("[TB] FAIL partial_data: got %h expected 0000bbaa", dataOut); else passCnt++;
    totalCnt++; if ({strbOut, lastOut} !== 5'b00111) $display("[TB] FAIL partial_strb_last: got %b/%b expected 0011/1", strbOut, lastOut); else passCnt++;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    totalCnt++; if ({dataOut, strbOut, lastOut} !== {32'hFFEEDDCC, 4'hF, 1'b1}) $display("[TB] FAIL partial_second: got %h/%b/%b expected ffeeddcc/1111/1", dataOut, strbOut, lastOut); else passCnt++;
    totalCnt++; if (pktCntOut !== 5'd1) $display("[TB] FAIL partial_pkt: got %0d expected 1", pktCntOut); else passCnt++;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    totalCnt++; if (levelOut !== 5'd0) $display("[TB] FAIL partial_drain: got %0d expected 0", levelOut); else passCnt++;
  endtask

  task automatic test_fill_full();
    int w;
    logic [7:0] b0;
    logic [DATA_W+4:0] expWord;
    ready = 1'b0;
    for (int i = 0; i < 68; i++) applyStimulus(8'(i), (i % 8) == 7);
    totalCnt++; if (levelOut !== 5'd16) $display("[TB] FAIL fill_level: got %0d expected 16", levelOut); else passCnt++;
    totalCnt++; if (pktCntOut !== 5'd8) $display("[TB] FAIL fill_pkt: got %0d expected 8", pktCntOut); else passCnt++;
    axis.tvalid = 1'b1;
    axis.tdata  = 8'hEE;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      totalCnt++; if (axis.tready !== 1'b0) $display("[TB] FAIL fill_tready_cycle%0d: got %b expected 0", c, axis.tready); else passCnt++;
    end
    axis.tvalid = 1'b0;
    totalCnt++; if (levelOut !== 5'd16) $display("[TB] FAIL fill_level_hold: got %0d expected 16", levelOut); else passCnt++;
    ready = 1'b1;
    w     = 0;
    for (int c = 0; c < 60 && w < 17; c++) begin
      if (validOut) begin
        b0      = 8'(4 * w);
        expWord = {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0, 4'hF, (w % 2) == 1};
        totalCnt++; if ({dataOut, strbOut, lastOut} !== expWord) $display("[TB] FAIL drain_word%0d: got %h expected %h", w, {dataOut, strbOut, lastOut}, expWord); else passCnt++;
        w++;
      end
      @(negedge clk);
    end
    ready = 1'b0;
    totalCnt++; if (w !== 17) $display("[TB] FAIL drain_count: got %0d words expected 17", w); else passCnt++;
    totalCnt++; if ({levelOut, pktCntOut} !== 10'd0) $display("[TB] FAIL drain_empty: got level=%0d pkt=%0d expected 0/0", levelOut, pktCntOut); else passCnt++;
  endtask

  task automatic test_push_pop();
    ready = 1'b0;
    for (int j = 0; j < 6; j++) applyStimulus(8'hA0 + 8'(j), 1'b1);
    ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      totalCnt++; if (levelOut !== 5'd5) $display("[TB] FAIL pp_level%0d: got %0d expected 5", k, levelOut); else passCnt++;
      totalCnt++; if (pktCntOut !== 5'd5) $display("[TB] FAIL pp_pkt%0d: got %0d expected 5", k, pktCntOut); else passCnt++;
      totalCnt++; if ({dataOut, strbOut} !== {24'd0, 8'hA0 + 8'(k), 4'b0001}) $display("[TB] FAIL pp_head%0d: got %h/%b expected %h/0001", k, dataOut, strbOut, 8'hA0 + 8'(k)); else passCnt++;
      applyStimulus(8'hA6 + 8'(k), 1'b1);
    end
    repeat (10) @(negedge clk);
    ready = 1'b0;
    totalCnt++; if ({validOut, levelOut, pktCntOut} !== 11'd0) $display("[TB] FAIL pp_drain: got valid=%b level=%0d pkt=%0d expected 0/0/0", validOut, levelOut, pktCntOut); else passCnt++;
  endtask

  task automatic test_interrupt();
    ready     = 1'b0;
    threshold = 5'd3;
    lvlIntEn  = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      applyStimulus(8'h10 + 8'(j), 1'b1);
      @(negedge clk);
      totalCnt++; if (levelOut !== 5'(j)) $display("[TB] FAIL int_level%0d: got %0d expected %0d", j, levelOut, j); else passCnt++;
      totalCnt++; if (intOut !== (j > 3)) $display("[TB] FAIL int_lvl%0d: got %b expected %b", j, intOut, j > 3); else passCnt++;
    end
    lvlIntEn = 1'b0;
    pktIntEn = 1'b1;
    #1;
    totalCnt++; if (intOut !== 1'b1) $display("[TB] FAIL int_pkt_on: got %b expected 1", intOut); else passCnt++;
    @(negedge clk);
    ready = 1'b1;
    repeat (5) @(negedge clk);
    ready = 1'b0;
    totalCnt++; if ({levelOut, intOut} !== 6'd0) $display("[TB] FAIL int_drained: got level=%0d int=%b expected 0/0", levelOut, intOut); else passCnt++;
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'h03, 1'b0);
    applyStimulus(8'h04, 1'b0);
    @(negedge clk);
    totalCnt++; if ({levelOut, pktCntOut, intOut} !== {5'd1, 5'd0, 1'b0}) $display("[TB] FAIL int_nolast: got level=%0d pkt=%0d int=%b expected 1/0/0", levelOut, pktCntOut, intOut); else passCnt++;
    applyStimulus(8'h05, 1'b1);
    @(negedge clk);
    totalCnt++; if ({pktCntOut, intOut} !== {5'd1, 1'b1}) $display("[TB] FAIL int_last_in: got pkt=%0d int=%b expected 1/1", pktCntOut, intOut); else passCnt++;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    totalCnt++; if ({intOut, lastOut} !== 2'b11) $display("[TB] FAIL int_after_first_pop: got int=%b last=%b expected 1/1", intOut, lastOut); else passCnt++;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    totalCnt++; if ({pktCntOut, intOut} !== 6'd0) $display("[TB] FAIL int_last_popped: got pkt=%0d int=%b expected 0/0", pktCntOut, intOut); else passCnt++;
    pktIntEn = 1'b0;
  endtask

  task automatic test_cke();
    ready = 1'b0;
    applyStimulus(8'h77, 1'b1);
    @(negedge clk);
    cke         = 1'b0;
    ready       = 1'b1;
    axis.tvalid = 1'b1;
    axis.tdata  = 8'h88;
    repeat (2) @(negedge clk);
    totalCnt++; if ({levelOut, validOut, axis.tready} !== {5'd1, 1'b1, 1'b0}) $display("[TB] FAIL cke_hold: got level=%0d valid=%b tready=%b expected 1/1/0", levelOut, validOut, axis.tready); else passCnt++;
    axis.tvalid = 1'b0;
    cke         = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    totalCnt++; if (levelOut !== 5'd0) $display("[TB] FAIL cke_resume: got %0d expected 0", levelOut); else passCnt++;
  endtask

  task automatic test_reset_mid();
    ready = 1'b0;
    applyStimulus(8'h21, 1'b0);
    applyStimulus(8'h22, 1'b0);
    applyStimulus(8'h23, 1'b0);
    applyStimulus(8'h24, 1'b1);
    @(negedge clk);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h02, 1'b0);
    axis.tvalid = 1'b1;
    axis.tdata  = 8'h03;
    rst         = 1'b1;
    #1;
    totalCnt++; if (axis.tready !== 1'b0) $display("[TB] FAIL midrst_tready: got %b expected 0", axis.tready); else passCnt++;
    @(negedge clk);
    rst         = 1'b0;
    axis.tvalid = 1'b0;
    totalCnt++; if ({levelOut, validOut, pktCntOut} !== 11'd0) $display("[TB] FAIL midrst_clear: got level=%0d valid=%b pkt=%0d expected 0/0/0", levelOut, validOut, pktCntOut); else passCnt++;
    applyStimulus(8'h55, 1'b0);
    applyStimulus(8'h66, 1'b1);
    @(negedge clk);
    totalCnt++; if ({dataOut, strbOut, lastOut} !== {32'h00006655, 4'b0011, 1'b1}) $display("[TB] FAIL midrst_next: got %h/%b/%b expected 00006655/0011/1", dataOut, strbOut, lastOut); else passCnt++;
    totalCnt++; if (levelOut !== 5'd1) $display("[TB] FAIL midrst_level: got %0d expected 1", levelOut); else passCnt++;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  initial begin
    cke         = 1'b1;
    rst         = 1'b1;
    enable      = 1'b0;
    ready       = 1'b0;
    threshold   = 5'd3;
    lvlIntEn    = 1'b0;
    pktIntEn    = 1'b0;
    axis.tdata  = '0;
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    $display("[TB] starting");
    test_reset();
    test_full_word();
    test_partial();
    test_fill_full();
    test_push_pop();
    test_interrupt();
    test_cke();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time %0t reached, required completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
